// File: rtl/vga_vblank_reg_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | vga_vblank_reg_sched: queues CPU stores to VGA registers and applies     |
// | them one per clock, in order, only during vertical blanking.             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module vga_vblank_reg_sched #(
  parameter int DEPTH   = 8,
  parameter int VACTIVE = 480
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [15:0] wr_data,
  input  logic [9:0] VPix,
  output logic       displayBlack,
  output logic [7:0] displayColor,
  output logic [9:0] HLocation1,
  output logic [9:0] VLocation1,
  output logic       sprite1On,
  output logic       sprite1White,
  output logic [7:0] textColor,
  output logic       wr_full,
  output logic       pending,
  output logic       wr_ovf,
  output logic [7:0] frame_cnt
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [9:0] VACT     = 10'(VACTIVE);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [0:0] S_WAIT   = 1'b0;
  localparam logic [0:0] S_DRAIN  = 1'b1;

  logic [12:0]   mem_q [DEPTH];
  logic [0:0]    state_q, state_d;
  logic          vblank_q, vblank_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d, pend_q, pend_d, ovf_q, ovf_d;
  logic [7:0]    frame_q, frame_d;
  logic          black_q, black_d, spr_on_q, spr_on_d, spr_wh_q, spr_wh_d;
  logic [7:0]    dcolor_q, dcolor_d, tcolor_q, tcolor_d;
  logic [9:0]    hloc_q, hloc_d, vloc_q, vloc_d;

  logic        vblank, vb_rise, pop, push_req, push;
  logic [12:0] head;
  logic        unused_ok;

  assign unused_ok = ^wr_data[15:10];
  assign vblank    = (VPix >= VACT);
  assign vb_rise   = vblank & ~vblank_q;
  assign head      = mem_q[rd_ptr_q];

  // State register
  always_ff @(posedge CLK) begin
    if (CLR) state_q <= S_WAIT;
    else     state_q <= state_d;
  end

  // Next state: leave DRAIN when blanking ends or the queue runs dry this cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT:  if (vb_rise) state_d = S_DRAIN;
      S_DRAIN: if (!vblank || count_d == '0) state_d = S_WAIT;
      default: state_d = S_WAIT;
    endcase
  end

  // FSM output: pop decision
  always_comb begin
    pop = 1'b0;
    if (state_q == S_DRAIN && count_q != '0 && vblank) pop = 1'b1;
  end

  always_comb begin
    push_req = wr_en && (wr_addr != 3'b111);
    push     = push_req && (count_q != FULL_CNT || pop);
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
    full_d   = (count_d == FULL_CNT);
    pend_d   = (count_d != '0);
    ovf_d    = ovf_q | (push_req & ~push);
    frame_d  = vb_rise ? frame_q + 8'd1 : frame_q;
    vblank_d = vblank;

    black_d  = black_q;
    dcolor_d = dcolor_q;
    hloc_d   = hloc_q;
    vloc_d   = vloc_q;
    spr_on_d = spr_on_q;
    spr_wh_d = spr_wh_q;
    tcolor_d = tcolor_q;
    if (pop) begin
      case (head[12:10])
        3'b000:  hloc_d   = head[9:0];
        3'b001:  vloc_d   = head[9:0];
        3'b010:  black_d  = head[0];
        3'b011:  dcolor_d = head[7:0];
        3'b100:  spr_on_d = head[0];
        3'b101:  spr_wh_d = head[0];
        3'b110:  tcolor_d = head[7:0];
        default: ;
      endcase
    end
  end

  // Storage needs no reset: pointers and count define validity
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= {wr_addr, wr_data[9:0]};
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      vblank_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      pend_q   <= 1'b0;
      ovf_q    <= 1'b0;
      frame_q  <= 8'h00;
      black_q  <= 1'b0;
      dcolor_q <= 8'h00;
      hloc_q   <= 10'd0;
      vloc_q   <= 10'd0;
      spr_on_q <= 1'b1;
      spr_wh_q <= 1'b0;
      tcolor_q <= 8'hFF;
    end else begin
      vblank_q <= vblank_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      pend_q   <= pend_d;
      ovf_q    <= ovf_d;
      frame_q  <= frame_d;
      black_q  <= black_d;
      dcolor_q <= dcolor_d;
      hloc_q   <= hloc_d;
      vloc_q   <= vloc_d;
      spr_on_q <= spr_on_d;
      spr_wh_q <= spr_wh_d;
      tcolor_q <= tcolor_d;
    end
  end

  assign displayBlack = black_q;
  assign displayColor = dcolor_q;
  assign HLocation1   = hloc_q;
  assign VLocation1   = vloc_q;
  assign sprite1On    = spr_on_q;
  assign sprite1White = spr_wh_q;
  assign textColor    = tcolor_q;
  assign wr_full      = full_q;
  assign pending      = pend_q;
  assign wr_ovf       = ovf_q;
  assign frame_cnt    = frame_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_vblank_reg_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_vga_vblank_reg_sched: directed self-checking bench for the vblank     |
// | register update scheduler.                                               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_vga_vblank_reg_sched;

  logic       CLK = 1'b0;
  logic       CLR;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [15:0] wr_data;
  logic [9:0] VPix;
  logic       displayBlack, sprite1On, sprite1White, wr_full, pending, wr_ovf;
  logic [7:0] displayColor, textColor, frame_cnt;
  logic [9:0] HLocation1, VLocation1;

  int n_checks = 0;
  int n_pass   = 0;

  vga_vblank_reg_sched #(.DEPTH(8), .VACTIVE(480)) dut (
    .CLK(CLK), .CLR(CLR), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .VPix(VPix), .displayBlack(displayBlack), .displayColor(displayColor),
    .HLocation1(HLocation1), .VLocation1(VLocation1), .sprite1On(sprite1On),
    .sprite1White(sprite1White), .textColor(textColor), .wr_full(wr_full),
    .pending(pending), .wr_ovf(wr_ovf), .frame_cnt(frame_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " displayBlack"}, 16'(displayBlack), 16'd0);
    chk({tag, " displayColor"}, 16'(displayColor), 16'h00);
    chk({tag, " textColor"},    16'(textColor),    16'hFF);
    chk({tag, " HLocation1"},   16'(HLocation1),   16'd0);
    chk({tag, " VLocation1"},   16'(VLocation1),   16'd0);
    chk({tag, " sprite1On"},    16'(sprite1On),    16'd1);
    chk({tag, " sprite1White"}, 16'(sprite1White), 16'd0);
    chk({tag, " frame_cnt"},    16'(frame_cnt),    16'd0);
    chk({tag, " wr_ovf"},       16'(wr_ovf),       16'd0);
    chk({tag, " wr_full"},      16'(wr_full),      16'd0);
    chk({tag, " pending"},      16'(pending),      16'd0);
  endtask

  initial begin
    CLR = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'd0; VPix = 10'd0;
    tick(); tick();
    CLR = 1'b0;
    tick();
    chk_reset_vals("reset");

    // Deferred apply
    VPix = 10'd100;
    push(3'd0, 16'd300);
    push(3'd1, 16'd200);
    tick();
    chk("defer H held", 16'(HLocation1), 16'd0);
    chk("defer V held", 16'(VLocation1), 16'd0);
    chk("defer pending", 16'(pending), 16'd1);
    VPix = 10'd480;
    tick();
    chk("defer frame_cnt", 16'(frame_cnt), 16'd1);
    chk("defer H at t0", 16'(HLocation1), 16'd0);
    tick();
    chk("defer H at t0+1", 16'(HLocation1), 16'd300);
    chk("defer V at t0+1", 16'(VLocation1), 16'd0);
    tick();
    chk("defer V at t0+2", 16'(VLocation1), 16'd200);
    chk("defer pending drained", 16'(pending), 16'd0);
    VPix = 10'd0;
    tick(); tick();

    // Blanking ends after 3 pops
    for (int i = 0; i < 8; i++) push(3'd6, 16'(10 + i));
    chk("partial full", 16'(wr_full), 16'd1);
    VPix = 10'd480;
    tick();
    chk("partial frame_cnt", 16'(frame_cnt), 16'd2);
    tick(); tick(); tick();
    chk("partial third applied", 16'(textColor), 16'd12);
    VPix = 10'd0;
    tick(); tick();
    chk("partial held after vblank", 16'(textColor), 16'd12);
    chk("partial pending", 16'(pending), 16'd1);
    chk("partial not full", 16'(wr_full), 16'd0);
    VPix = 10'd480;
    tick();
    chk("partial frame_cnt 2nd", 16'(frame_cnt), 16'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("partial resume order", 16'(textColor), 16'(13 + i));
    end
    chk("partial drained", 16'(pending), 16'd0);
    VPix = 10'd0;
    tick(); tick();

    // Address 7 ignored, then push during a pop while full
    push(3'd7, 16'd5);
    tick();
    chk("addr7 pending", 16'(pending), 16'd0);
    chk("addr7 ovf", 16'(wr_ovf), 16'd0);
    for (int i = 0; i < 8; i++) push(3'd0, 16'(1 + i));
    VPix = 10'd480;
    tick();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'd9;
    tick();
    wr_en = 1'b0;
    chk("fullpop H", 16'(HLocation1), 16'd1);
    chk("fullpop still full", 16'(wr_full), 16'd1);
    chk("fullpop ovf", 16'(wr_ovf), 16'd0);
    for (int i = 0; i < 8; i++) tick();
    chk("fullpop last applied", 16'(HLocation1), 16'd9);
    chk("fullpop drained", 16'(pending), 16'd0);
    VPix = 10'd0;
    tick(); tick();

    // Overflow
    for (int i = 0; i < 8; i++) push(3'd3, 16'(1 + i));
    chk("ovf full after 8", 16'(wr_full), 16'd1);
    chk("ovf clear after 8", 16'(wr_ovf), 16'd0);
    push(3'd3, 16'd9);
    chk("ovf set after 9", 16'(wr_ovf), 16'd1);
    VPix = 10'd480;
    tick();
    chk("ovf frame_cnt", 16'(frame_cnt), 16'd5);
    tick();
    chk("ovf first color", 16'(displayColor), 16'd1);
    for (int i = 0; i < 7; i++) tick();
    chk("ovf final color", 16'(displayColor), 16'd8);
    chk("ovf drained", 16'(pending), 16'd0);
    chk("ovf sticky", 16'(wr_ovf), 16'd1);
    VPix = 10'd0;
    tick(); tick();

    // Reset in the middle of a drain
    for (int i = 0; i < 6; i++) push(3'd1, 16'(50 + i));
    VPix = 10'd480;
    tick();
    tick();
    chk("midclr first pop", 16'(VLocation1), 16'd50);
    CLR = 1'b1; VPix = 10'd0;
    tick();
    CLR = 1'b0;
    chk_reset_vals("midclr");
    VPix = 10'd480;
    tick();
    chk("midclr new frame", 16'(frame_cnt), 16'd1);
    for (int i = 0; i < 7; i++) tick();
    chk("midclr no stale V", 16'(VLocation1), 16'd0);
    chk("midclr no stale pending", 16'(pending), 16'd0);

    // frame_cnt wraps after 255 more blanking entries
    VPix = 10'd0;
    tick();
    for (int i = 0; i < 255; i++) begin
      VPix = 10'd480; tick(); tick();
      VPix = 10'd0;   tick(); tick();
    end
    chk("frame_cnt wrap", 16'(frame_cnt), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vga_vblank_reg_sched.md
# vga_vblank_reg_sched

Tear-free register update scheduler for the VGA sprite/overlay block. CPU stores to the VGA register space go into a small FIFO. They are applied to the display configuration registers only during vertical blanking, one per clock, in program order. It sits between the CPU store decode (`data_addr[15:14]==2'b11`) and the sprite/pixel compositor, and replaces direct register writes.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO entries. Must be a power of two, at least 2.
- `VACTIVE`, default 480: first `VPix` value considered vertical blank.

Ports:
- `CLK` in 1: system clock, single clock domain.
- `CLR` in 1: synchronous, active-high reset.
- `wr_en` in 1: decoded CPU store strobe to VGA register space, one-cycle pulse per store.
- `wr_addr` in 3: register select (`data_addr[2:0]`).
- `wr_data` in 16: store data (`data_in`).
- `VPix` in 10: current line from the vertical counter.
- `displayBlack` out 1: addr 3'b010, `wr_data[0]`.
- `displayColor` out 8: addr 3'b011, `wr_data[7:0]`.
- `HLocation1` out 10: addr 3'b000, `wr_data[9:0]`.
- `VLocation1` out 10: addr 3'b001, `wr_data[9:0]`.
- `sprite1On` out 1: addr 3'b100, `wr_data[0]`.
- `sprite1White` out 1: addr 3'b101, `wr_data[0]`.
- `textColor` out 8: addr 3'b110, `wr_data[7:0]`.
- `wr_full` out 1: FIFO holds `DEPTH` entries.
- `pending` out 1: FIFO non-empty.
- `wr_ovf` out 1: sticky; a store was dropped.
- `frame_cnt` out 8: count of vblank entries, wraps.

## Operation
- Entry format is {`wr_addr`, `wr_data[9:0]`} (13 bits).
- Stores with `wr_addr`=3'b111 are ignored: not queued, no overflow.
- Push:
  - A push is accepted when `wr_en` is high and either `!wr_full` or a pop occurs in the same cycle.
  - Otherwise the store is dropped and `wr_ovf` is set to 1. `wr_ovf` clears only on `CLR`.
- Blanking detection:
  - `vblank` = (`VPix` >= `VACTIVE`).
  - `vblank_q` is `vblank` registered, reset 0.
  - `vb_rise` = `vblank` & !`vblank_q`.
- FSM has two states, WAIT and DRAIN; reset state is WAIT.
  - WAIT -> DRAIN on `vb_rise`. `frame_cnt` increments on the same edge, whether or not the FIFO is empty.
  - In DRAIN, each cycle with FIFO non-empty and `vblank` high pops the head entry. The addressed output register updates on that same edge.
  - DRAIN -> WAIT when the FIFO will be empty after this cycle's pop/push, or when `vblank` is low.
  - Entries pushed during DRAIN while blanking persists are drained in the same blanking interval.
- Order is strict FIFO. Several writes to the same register in one interval: the last one wins. Non-addressed registers hold their value.
- Entries left when blanking ends stay queued for the next `vb_rise`.
- Reset values:
  - `displayBlack`=0, `displayColor`=8'h00, `textColor`=8'hFF.
  - `HLocation1`=0, `VLocation1`=0, `sprite1On`=1, `sprite1White`=0.
  - `frame_cnt`=0, `wr_ovf`=0, `wr_full`=0, `pending`=0.
  - FIFO pointers are 0.
- `CLR` mid-drain discards all queued entries and restores the reset values on the next edge.
- If `VPix` >= `VACTIVE` when `CLR` deasserts, `vb_rise` is seen on the first cycle and a DRAIN follows.

## Timing
- Push: an entry written at edge t shows `pending`=1 and an updated `wr_full` after edge t.
- Apply latency: `VPix` reaches `VACTIVE` before edge t0, so state=DRAIN and `frame_cnt`+1 after t0.
  - The first entry is applied at edge t0+1.
  - Entry k is applied at edge t0+k.
- At most one register update per cycle. Outputs are registered; there are no combinational paths from inputs to outputs.
- Simultaneous push and pop when full: both occur, the count is unchanged, `wr_ovf` is unchanged.
- Simultaneous push and pop when empty is not possible, because pop requires non-empty at the start of the cycle. The pushed entry pops on a later cycle.
- `frame_cnt` wraps 8'hFF -> 8'h00.
- `VPix` changes once per 4 `CLK`. Edge detection must tolerate this: there is exactly one `vb_rise` per frame.

## Test plan
- Reset: assert `CLR` for 2 cycles. Check all outputs at their reset values, including `textColor`=8'hFF and `sprite1On`=1.
- Deferred apply:
  - With `VPix`=100, push addr 0 data 10'd300 and addr 1 data 10'd200. Check `HLocation1`/`VLocation1` stay 0 and `pending`=1.
  - Step `VPix` to 480. Check `HLocation1`=300 at t0+1, `VLocation1`=200 at t0+2, `pending`=0 after, `frame_cnt`=1.
- Overflow:
  - With `VPix`=0, push 9 stores to addr 3 (data 1..9). Check `wr_full`=1 after the 8th, and that the 9th is dropped with `wr_ovf`=1.
  - At vblank, check `displayColor` ends at 8 after 8 cycles.
- Blanking ends mid-drain: queue 8 entries, hold `vblank` for 3 cycles only. Check 3 entries are applied, 5 remain, and the rest apply at the next vblank in order.
- Addr 3'b111 plus full-with-pop:
  - A store to addr 7 leaves `pending`=0.
  - During DRAIN with a full FIFO, a push in a pop cycle is accepted with `wr_ovf`=0.
- Reset mid-drain: assert `CLR` at t0+2 with 6 queued. Check the queue is empty and registers return to reset values; no stale entry applies at the next vblank.
